// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The FSM state is one bit wide.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbState_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purely combinational round-robin picker: first set request strictly after 'last', wrapping modulo NREQ.
// Reusable by any shared-resource arbiter that keeps its own last-grant register.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [IDW-1:0]  grant_o,
  output logic            anyReq_o
);

  logic [IDW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit overrides.
  always_comb begin
    grant_o  = '0;
    anyReq_o = 1'b0;
    idx      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last_i) + k) % NREQ);
      if (req_i[idx]) begin
        grant_o  = idx;
        anyReq_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NREQ producers with round-robin grants of at most MAX_BURST words.
// One arbitration bubble per grant; fifo_full gates the transfer combinationally.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DW-1:0]           fifo_din,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  arbState_e      state_q;
  logic [IDW-1:0] grantId_q;
  logic [IDW-1:0] lastGrant_q;
  logic [BCW-1:0] burstCnt_q;
  logic [CNT_W-1:0] wordCnt_q;

  logic [IDW-1:0] pickIdx;
  logic           anyReq;
  logic           inBurst;
  logic           grantValid;
  logic           xfer;
  logic           lastBeat;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i    (req_valid),
    .last_i   (lastGrant_q),
    .grant_o  (pickIdx),
    .anyReq_o (anyReq)
  );

  assign inBurst    = (state_q == BURST);
  assign grantValid = req_valid[grantId_q];
  assign xfer       = inBurst && grantValid && !fifo_full;
  assign lastBeat   = (burstCnt_q == BCW'(MAX_BURST - 1));

  assign fifo_wr  = xfer;
  assign busy     = inBurst;
  assign grant_id = grantId_q;
  assign word_cnt = wordCnt_q;
  assign fifo_din = inBurst ? req_data[int'(grantId_q) * DW +: DW] : '0;

  always_comb begin
    req_ready = '0;
    if (inBurst) begin
      req_ready[grantId_q] = !fifo_full;
    end
  end

  // A dropped valid releases the grant before any burst-length check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grantId_q   <= '0;
      lastGrant_q <= IDW'(NREQ - 1);
      burstCnt_q  <= '0;
      wordCnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            grantId_q   <= pickIdx;
            lastGrant_q <= pickIdx;
            burstCnt_q  <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (!grantValid) begin
            state_q <= IDLE;
          end else if (xfer) begin
            burstCnt_q <= burstCnt_q + 1'b1;
            wordCnt_q  <= wordCnt_q + 1'b1;
            if (lastBeat) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, compared each
// cycle against a grant/word-count reference model driven by per-lane producer queues.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rstN;
  logic [NREQ-1:0]     reqValid;
  logic [NREQ*DW-1:0]  reqData;
  logic [NREQ-1:0]     reqReady;
  logic                fifoFull;
  logic                fifoWr;
  logic [DW-1:0]       fifoDin;
  logic [IDW-1:0]      grantId;
  logic                busyO;
  logic [15:0]         wordCnt;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req_valid (reqValid),
    .req_data  (reqData),
    .req_ready (reqReady),
    .fifo_full (fifoFull),
    .fifo_wr   (fifoWr),
    .fifo_din  (fifoDin),
    .grant_id  (grantId),
    .busy      (busyO),
    .word_cnt  (wordCnt)
  );

  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [DW-1:0]   laneQ[NREQ][$];
  logic [NREQ-1:0] dropMask;

  bit mBusy;
  int mGid, mLast, mWords, mCnt, totalWrites;
  bit prevBusy;
  int grantLog[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mBusy  = 1'b0;
    mGid   = 0;
    mLast  = NREQ - 1;
    mWords = 0;
    mCnt   = 0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (laneQ[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle from the lane queues, check outputs mid-cycle, then advance the model past the edge.
  task automatic applyStimulus();
    logic            eWr;
    logic [NREQ-1:0] eReady;
    logic [DW-1:0]   eDin;
    for (int i = 0; i < NREQ; i++) begin
      reqValid[i] = (laneQ[i].size() > 0) && !dropMask[i];
      if (laneQ[i].size() > 0) reqData[i*DW +: DW] = laneQ[i][0];
      else                     reqData[i*DW +: DW] = DW'($urandom);
    end
    eWr    = mBusy && reqValid[mGid] && !fifoFull;
    eReady = (mBusy && !fifoFull) ? (NREQ'(1) << mGid) : '0;
    eDin   = mBusy ? reqData[mGid*DW +: DW] : '0;
    #1;
    checkOutput("busy",     32'(busyO),    32'(mBusy));
    checkOutput("grantId",  32'(grantId),  32'(mGid));
    checkOutput("fifoWr",   32'(fifoWr),   32'(eWr));
    checkOutput("reqReady", 32'(reqReady), 32'(eReady));
    checkOutput("fifoDin",  32'(fifoDin),  32'(eDin));
    checkOutput("wordCnt",  32'(wordCnt),  32'(mWords));
    if (fifoFull) checkOutput("noWrWhileFull", 32'(fifoWr), 32'(0));
    if (busyO && !prevBusy) grantLog.push_back(int'(grantId));
    prevBusy = busyO;
    @(posedge clk);
    if (!mBusy) begin
      if (reqValid != '0) begin
        bit found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && reqValid[(mLast + k) % NREQ]) begin
            found = 1'b1;
            mGid  = (mLast + k) % NREQ;
          end
        end
        mLast = mGid;
        mCnt  = 0;
        mBusy = 1'b1;
      end
    end else if (!reqValid[mGid]) begin
      mBusy = 1'b0;
    end else if (!fifoFull) begin
      void'(laneQ[mGid].pop_front());
      mWords = (mWords + 1) % 65536;
      totalWrites++;
      mCnt++;
      if (mCnt == MAX_BURST) mBusy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic doReset(input bit clearQ);
    rstN     = 1'b0;
    dropMask = '0;
    fifoFull = 1'b0;
    #1;
    checkOutput("rstBusy",     32'(busyO),    32'(0));
    checkOutput("rstFifoWr",   32'(fifoWr),   32'(0));
    checkOutput("rstReqReady", 32'(reqReady), 32'(0));
    checkOutput("rstFifoDin",  32'(fifoDin),  32'(0));
    checkOutput("rstWordCnt",  32'(wordCnt),  32'(0));
    checkOutput("rstGrantId",  32'(grantId),  32'(0));
    resetModel();
    prevBusy = 1'b0;
    if (clearQ) for (int i = 0; i < NREQ; i++) laneQ[i].delete();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    dropMask = '0;
    fifoFull = 1'b0;
    while ((pending() || mBusy) && n < limit) begin
      applyStimulus();
      n++;
    end
    checkOutput("drainInBound", 32'(n < limit), 32'(1));
  endtask

  initial begin
    int expOrder[5] = '{0, 1, 2, 3, 0};
    int n;
    rstN     = 1'b0;
    reqValid = '0;
    reqData  = '0;
    fifoFull = 1'b0;
    dropMask = '0;
    totalWrites = 0;
    resetModel();
    @(negedge clk);

    // Single requester: two grants of 4 then 2 words with one bubble between.
    doReset(1'b1);
    grantLog.delete();
    for (int w = 0; w < 6; w++) laneQ[0].push_back(DW'(8'hA1 + w));
    drain(100);
    checkOutput("t1WordCnt", 32'(wordCnt), 32'(6));
    checkOutput("t1GrantId", 32'(grantId), 32'(0));
    checkOutput("t1Grants",  32'(grantLog.size()), 32'(2));

    // All lanes requesting: strict rotation from lane 0.
    doReset(1'b1);
    grantLog.delete();
    for (int i = 0; i < NREQ; i++)
      for (int w = 0; w < 8; w++) laneQ[i].push_back(DW'($urandom));
    repeat (5 * (MAX_BURST + 1)) applyStimulus();
    checkOutput("t2GrantCount", 32'(grantLog.size()), 32'(5));
    for (int i = 0; i < 5 && i < grantLog.size(); i++)
      checkOutput("t2GrantOrder", 32'(grantLog[i]), 32'(expOrder[i]));
    drain(200);

    // Lane 2 stalled by fifo_full for 3 cycles after 2 words.
    grantLog.delete();
    for (int w = 0; w < 4; w++) laneQ[2].push_back(DW'($urandom));
    repeat (3) applyStimulus();
    fifoFull = 1'b1;
    repeat (3) applyStimulus();
    fifoFull = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("t3Released", 32'(busyO),   32'(0));
    checkOutput("t3GrantId",  32'(grantId), 32'(2));
    drain(20);

    // Lane 1 drops after one word; lane 3 is granted next.
    laneQ[1].push_back(DW'($urandom));
    applyStimulus();
    for (int w = 0; w < 8; w++) laneQ[3].push_back(DW'($urandom));
    repeat (3) applyStimulus();
    checkOutput("t4GrantId", 32'(grantId), 32'(3));
    checkOutput("t4Busy",    32'(busyO),   32'(1));

    // Reset mid-burst on lane 3, then lane 0 wins first with everyone requesting.
    repeat (2) applyStimulus();
    doReset(1'b0);
    grantLog.delete();
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 4; w++) laneQ[i].push_back(DW'($urandom));
    applyStimulus();
    checkOutput("t5FirstGrant", 32'(grantId), 32'(0));
    checkOutput("t5Busy",       32'(busyO),   32'(1));
    drain(200);

    // Randomized traffic with valid drops and full back-pressure.
    repeat (1500) begin
      for (int i = 0; i < NREQ; i++) begin
        if (laneQ[i].size() < 6 && $urandom_range(0, 2) == 0) laneQ[i].push_back(DW'($urandom));
        dropMask[i] = ($urandom_range(0, 7) == 0);
      end
      fifoFull = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end
    drain(500);

    // Word counter wrap: 65537 writes leave word_cnt at 1.
    doReset(1'b1);
    totalWrites = 0;
    n = 0;
    while (totalWrites < 65537 && n < 90000) begin
      if (laneQ[0].size() < 3) laneQ[0].push_back(DW'($urandom));
      applyStimulus();
      n++;
    end
    checkOutput("wrapWrites",  32'(totalWrites), 32'(65537));
    checkOutput("wrapWordCnt", 32'(wordCnt),     32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
